// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl
// Sequences the control-hazard stall between ID, IF, IFID and WB.
// When ID flags a possibly-jumping instruction, fetch is frozen and NOPs are
// fed to ID until WB commits it. The block then issues the redirect (if
// taken) and inserts one extra NOP to flush the stale IFID entry.
//
// Ports:
//   clk           single clock, all state changes on posedge
//   rst           synchronous active-high reset
//   id_branch_det ID decoded a possibly-jumping instruction
//   wb_valid      WB commits an instruction
//   wb_is_jump    committed instruction is the flagged jump/branch
//   wb_taken      branch resolved taken
//   wb_target     resolved target address
//   stall         freeze fetch / forward NOP (to IF and IFID)
//   pc_hold       one-cycle pulse on stall rising: IF reloads current PC
//   ifid_nop      IFID presents NOP to ID
//   jump_en       one-cycle redirect strobe
//   jump_addr     redirect target, holds last value
//   timeout_err   sticky watchdog expiry flag
//   stall_cycles  saturating count of cycles with stall=1
module branch_stall_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_branch_det,
    input  logic              wb_valid,
    input  logic              wb_is_jump,
    input  logic              wb_taken,
    input  logic [ADDR_W-1:0] wb_target,
    output logic              stall,
    output logic              pc_hold,
    output logic              ifid_nop,
    output logic              jump_en,
    output logic [ADDR_W-1:0] jump_addr,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Watchdog width; kept at least 1 bit so TIMEOUT=0 still elaborates.
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;

    logic              stall_d;
    logic              pc_hold_d;
    logic              ifid_nop_d;
    logic              jump_en_d;
    logic [ADDR_W-1:0] jump_addr_d;
    logic              timeout_err_d;
    logic [CNT_W-1:0]  stall_cycles_d;

    logic              resolve;
    logic              wd_expire;

    assign resolve   = wb_valid & wb_is_jump;
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

    // State, watchdog and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            stall        <= 1'b0;
            pc_hold      <= 1'b0;
            ifid_nop     <= 1'b0;
            jump_en      <= 1'b0;
            jump_addr    <= '0;
            timeout_err  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            stall        <= stall_d;
            pc_hold      <= pc_hold_d;
            ifid_nop     <= ifid_nop_d;
            jump_en      <= jump_en_d;
            jump_addr    <= jump_addr_d;
            timeout_err  <= timeout_err_d;
            stall_cycles <= stall_cycles_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        stall_d       = 1'b0;
        pc_hold_d     = 1'b0;
        ifid_nop_d    = 1'b0;
        jump_en_d     = 1'b0;
        jump_addr_d   = jump_addr;
        timeout_err_d = timeout_err;

        case (state_q)
            S_IDLE: begin
                if (id_branch_det) begin
                    state_d    = S_STALL;
                    wd_d       = '0;
                    stall_d    = 1'b1;
                    pc_hold_d  = 1'b1;
                    ifid_nop_d = 1'b1;
                end
            end
            S_STALL: begin
                // Resolve takes priority over a simultaneous watchdog expiry.
                if (resolve) begin
                    state_d    = S_FLUSH;
                    ifid_nop_d = 1'b1;
                    jump_en_d  = wb_taken;
                    if (wb_taken) begin
                        jump_addr_d = wb_target;
                    end
                end else if (wd_expire) begin
                    state_d       = S_FLUSH;
                    ifid_nop_d    = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    stall_d    = 1'b1;
                    ifid_nop_d = 1'b1;
                    wd_d       = wd_q + WD_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter tracks the stall output it is registered alongside.
        stall_cycles_d = stall_cycles;
        if (stall_d && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Self-checking bench for branch_stall_ctrl: two instances (watchdog of 8 with
// a 16-bit counter, watchdog disabled with a 4-bit counter) share stimulus and
// are compared every cycle against a behavioural model.
module tb_branch_stall_ctrl;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_branch_det;
    logic          wb_valid;
    logic          wb_is_jump;
    logic          wb_taken;
    logic [AW-1:0] wb_target;

    logic          stall0, pc_hold0, ifid_nop0, jump_en0, timeout_err0;
    logic [AW-1:0] jump_addr0;
    logic [15:0]   stall_cycles0;
    logic          stall1, pc_hold1, ifid_nop1, jump_en1, timeout_err1;
    logic [AW-1:0] jump_addr1;
    logic [3:0]    stall_cycles1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_stall_ctrl #(.ADDR_W(AW), .TIMEOUT(8), .CNT_W(16)) u_dut_wd (
        .clk(clk), .rst(rst), .id_branch_det(id_branch_det),
        .wb_valid(wb_valid), .wb_is_jump(wb_is_jump), .wb_taken(wb_taken),
        .wb_target(wb_target), .stall(stall0), .pc_hold(pc_hold0),
        .ifid_nop(ifid_nop0), .jump_en(jump_en0), .jump_addr(jump_addr0),
        .timeout_err(timeout_err0), .stall_cycles(stall_cycles0)
    );

    branch_stall_ctrl #(.ADDR_W(AW), .TIMEOUT(0), .CNT_W(4)) u_dut_nowd (
        .clk(clk), .rst(rst), .id_branch_det(id_branch_det),
        .wb_valid(wb_valid), .wb_is_jump(wb_is_jump), .wb_taken(wb_taken),
        .wb_target(wb_target), .stall(stall1), .pc_hold(pc_hold1),
        .ifid_nop(ifid_nop1), .jump_en(jump_en1), .jump_addr(jump_addr1),
        .timeout_err(timeout_err1), .stall_cycles(stall_cycles1)
    );

    // Reference model, one slot per instance.
    // age: number of cycles already spent stalled for the pending branch, -1 if none.
    int          m_limit [2] = '{8, 0};
    int          m_cmax  [2] = '{65535, 15};
    int          m_age   [2] = '{-1, -1};
    bit          m_flush [2];
    bit          m_jen   [2];
    logic [31:0] m_addr  [2];
    bit          m_terr  [2];
    int          m_cnt   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            m_age[k] = -1; m_flush[k] = 0; m_jen[k] = 0;
            m_addr[k] = '0; m_terr[k] = 0; m_cnt[k] = 0;
            return;
        end
        m_jen[k] = 0;
        if (m_age[k] >= 0) begin
            if (wb_valid && wb_is_jump) begin
                m_age[k] = -1; m_flush[k] = 1; m_jen[k] = wb_taken;
                if (wb_taken) m_addr[k] = wb_target;
            end else if (m_limit[k] != 0 && m_age[k] + 1 == m_limit[k]) begin
                m_age[k] = -1; m_flush[k] = 1; m_terr[k] = 1;
            end else begin
                m_age[k]++;
            end
        end else if (m_flush[k]) begin
            m_flush[k] = 0;
        end else if (id_branch_det) begin
            m_age[k] = 0;
        end
        if (m_age[k] >= 0 && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
    endtask

    task automatic check_all();
        check("wd.stall",     32'(stall0),        32'(m_age[0] >= 0));
        check("wd.pc_hold",   32'(pc_hold0),      32'(m_age[0] == 0));
        check("wd.ifid_nop",  32'(ifid_nop0),     32'(m_age[0] >= 0 || m_flush[0]));
        check("wd.jump_en",   32'(jump_en0),      32'(m_jen[0]));
        check("wd.jump_addr", jump_addr0,         m_addr[0]);
        check("wd.tmo_err",   32'(timeout_err0),  32'(m_terr[0]));
        check("wd.stall_cyc", 32'(stall_cycles0), 32'(m_cnt[0]));
        check("nw.stall",     32'(stall1),        32'(m_age[1] >= 0));
        check("nw.pc_hold",   32'(pc_hold1),      32'(m_age[1] == 0));
        check("nw.ifid_nop",  32'(ifid_nop1),     32'(m_age[1] >= 0 || m_flush[1]));
        check("nw.jump_en",   32'(jump_en1),      32'(m_jen[1]));
        check("nw.jump_addr", jump_addr1,         m_addr[1]);
        check("nw.tmo_err",   32'(timeout_err1),  32'(m_terr[1]));
        check("nw.stall_cyc", 32'(stall_cycles1), 32'(m_cnt[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_in();
        rst = 0; id_branch_det = 0; wb_valid = 0; wb_is_jump = 0;
        wb_taken = 0; wb_target = '0;
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; tick(); rst = 0;
    endtask

    task automatic resolve(input bit taken, input logic [31:0] tgt);
        wb_valid = 1; wb_is_jump = 1; wb_taken = taken; wb_target = tgt;
        tick(); idle_in();
    endtask

    task automatic detect();
        id_branch_det = 1; tick(); idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1;
        tick(); tick();
        check("reset.stall", 32'(stall0), 32'd0);
        rst = 0;

        // Taken branch: 4 stall cycles, redirect to 0x100.
        tick(); tick();
        detect();
        check("taken.pc_hold", 32'(pc_hold0), 32'd1);
        tick(); tick(); tick();
        resolve(1'b1, 32'h0000_0100);
        check("taken.jump_en", 32'(jump_en0), 32'd1);
        check("taken.jump_addr", jump_addr0, 32'h100);
        check("taken.stall_cyc", 32'(stall_cycles0), 32'd4);
        tick();
        check("taken.idle_nop", 32'(ifid_nop0), 32'd0);

        // Not-taken branch; det during STALL and FLUSH, spurious resolve in IDLE.
        detect();
        id_branch_det = 1; tick(); tick(); idle_in(); tick();
        resolve(1'b0, 32'hDEAD_BEEF);
        check("ntaken.jump_addr", jump_addr0, 32'h100);
        id_branch_det = 1; tick(); idle_in();
        resolve(1'b1, 32'h1234_5678);
        tick();

        // Watchdog: 8 stall cycles on the TIMEOUT=8 instance.
        do_reset();
        detect();
        repeat (7) tick();
        check("wd.still_stall", 32'(stall0), 32'd1);
        tick();
        check("wd.expired_err", 32'(timeout_err0), 32'd1);
        repeat (20) tick();
        check("wd.sticky", 32'(timeout_err0), 32'd1);
        resolve(1'b1, 32'h40);

        // Resolve on the expiry cycle wins.
        do_reset();
        detect();
        repeat (7) tick();
        resolve(1'b1, 32'h0000_0200);
        check("simul.jump_en", 32'(jump_en0), 32'd1);
        check("simul.tmo_err", 32'(timeout_err0), 32'd0);

        // No watchdog: 1000 cycles of stall, counter saturates at 15.
        do_reset();
        detect();
        repeat (1000) tick();
        check("nowd.stall", 32'(stall1), 32'd1);
        check("nowd.tmo_err", 32'(timeout_err1), 32'd0);
        check("nowd.sat", 32'(stall_cycles1), 32'd15);
        resolve(1'b1, 32'h300);
        tick();

        // Reset in the third stall cycle, then a stale resolve and a fresh branch.
        detect();
        tick(); tick();
        rst = 1; tick(); rst = 0;
        check("rstmid.stall", 32'(stall1), 32'd0);
        resolve(1'b1, 32'h500);
        check("rstmid.no_jump", 32'(jump_en1), 32'd0);
        detect();
        tick();
        resolve(1'b1, 32'h600);
        check("rstmid.restart", jump_addr1, 32'h600);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            id_branch_det = ($urandom_range(0, 3) == 0);
            wb_valid      = ($urandom_range(0, 2) != 0);
            wb_is_jump    = ($urandom_range(0, 5) == 0);
            wb_taken      = $urandom_range(0, 1) == 1;
            wb_target     = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_stall_ctrl.md
# branch_stall_ctrl

Sequencer for the control-hazard stall protocol between ID, IF, IFID and WB. When ID flags an instruction that may redirect control flow, the block freezes fetch, feeds NOPs into ID until WB commits that instruction, and issues the PC redirect. It then inserts one extra NOP to flush the stale IFID entry. It sits beside the pipeline registers and drives the stall, hold, NOP and redirect lines that IF and IFID consume.

## Interface
- ADDR_W, 32, width of PC / jump target.
- TIMEOUT, 64, max STALL cycles before forced release; 0 disables the watchdog.
- CNT_W, 16, width of the stall-cycle statistics counter.

- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- id_branch_det  in  1  ID decoded a possibly-jumping instruction this cycle.
- wb_valid  in  1  WB commits an instruction this cycle.
- wb_is_jump  in  1  committed instruction is the flagged jump/branch.
- wb_taken  in  1  branch resolved taken; only meaningful with wb_valid & wb_is_jump.
- wb_target  in  ADDR_W  resolved target address.
- stall  out  1  to IF and IFID: freeze fetch and forward NOP.
- pc_hold  out  1  one-cycle pulse on stall 0->1: IF reloads the current PC as next PC.
- ifid_nop  out  1  IFID must present NOP to ID.
- jump_en  out  1  one-cycle redirect strobe to IF.
- jump_addr  out  ADDR_W  redirect target; valid when jump_en=1, holds last value otherwise.
- timeout_err  out  1  sticky; set on watchdog expiry.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- All outputs are registered.
- Reset value of every output is 0, including jump_addr and stall_cycles. State resets to IDLE.
- States:
  - IDLE: stall=0, ifid_nop=0. On id_branch_det, go to STALL, set stall=1 and pc_hold=1, and clear the watchdog counter.
  - STALL: stall=1, ifid_nop=1, pc_hold=0 after the first cycle. id_branch_det is ignored.
  - STALL, on resolve (wb_valid & wb_is_jump): go to FLUSH. jump_en=wb_taken. If wb_taken, jump_addr=wb_target.
  - STALL, on watchdog: if TIMEOUT≠0 and the counter reaches TIMEOUT-1 without resolve, go to FLUSH with jump_en=0 and set timeout_err.
  - FLUSH: stall=0, ifid_nop=1, jump_en as set on entry. Unconditionally return to IDLE the next cycle. id_branch_det is ignored, since ID is receiving a NOP.
- Resolve and watchdog expiry in the same cycle: resolve wins; timeout_err is not set.
- wb_valid & wb_is_jump while in IDLE or FLUSH: ignored, with no output change.
- Watchdog counter: width $clog2(TIMEOUT+1), counts only in STALL.
- stall_cycles increments on each cycle stall=1 and saturates at all-ones.
- timeout_err is cleared only by rst.
- rst asserted in any state, including mid-STALL: on the next edge all outputs are 0 and the state is IDLE. No jump_en is issued for the abandoned branch.

## Timing
- id_branch_det at cycle N → stall=1 and pc_hold=1 at N+1. pc_hold=0 from N+2 onward.
- Resolve at cycle M, where M ≥ N+1 and the block is in STALL → at M+1: stall=0, ifid_nop=1, jump_en=wb_taken, jump_addr updated. At M+2: IDLE, ifid_nop=0, jump_en=0.
- Minimum sequence: resolve at N+1 gives stall=1 for exactly 1 cycle, then 1 FLUSH cycle.
- Watchdog with TIMEOUT=T: stall stays high for exactly T cycles, then 1 FLUSH cycle.
- A new id_branch_det can be accepted no earlier than the first IDLE cycle, which is M+2.
- Latency, detect to earliest redirect: 2 cycles.

## Test plan
- Taken branch: id_branch_det at cycle 5; resolve at cycle 9 with wb_taken=1 and wb_target=0x0000_0100 → stall=1 for cycles 6–9, pc_hold only at 6, jump_en=1 with jump_addr=0x100 at 10, ifid_nop=1 for cycles 6–10, IDLE at 11, stall_cycles=4.
- Not-taken branch: same stimulus with wb_taken=0 → identical stall/NOP timing, jump_en never asserted, jump_addr keeps its prior value.
- Watchdog: TIMEOUT=8, no resolve → stall high exactly 8 cycles, then FLUSH with jump_en=0, timeout_err=1 and staying 1. TIMEOUT=0 with no resolve for 1000 cycles → stall stays high, timeout_err=0.
- Simultaneous events: resolve on the cycle the watchdog expires → jump_en=1, timeout_err=0. Spurious wb_is_jump in IDLE → no output change. id_branch_det during STALL and FLUSH → ignored.
- Reset mid-STALL: rst pulse at the 3rd STALL cycle → all outputs 0 next cycle. A following resolve produces no jump_en. A fresh id_branch_det restarts normally.
- Counter saturation: CNT_W=4 with a 20-cycle stall → stall_cycles=15.
